// File: rtl/mg_tx_lane_if.sv
// mg_tx_lane_if
// Purpose : valid/ready word stream from the TX packet formatter into the
//           lane buffer.
// Signals : tx_data_in   - payload word (DATA_W bits)
//           tx_valid_in  - payload word valid
//           tx_ready_out - lane buffer can accept a word this cycle
// Modports: master - word source (formatter / testbench)
//           slave  - word sink (mg_tx_lane)
interface mg_tx_lane_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] tx_data_in;
  logic              tx_valid_in;
  logic              tx_ready_out;

  modport master (output tx_data_in, output tx_valid_in, input tx_ready_out);
  modport slave  (input tx_data_in, input tx_valid_in, output tx_ready_out);
endinterface

// File: rtl/mg_tx_lane.sv
// mg_tx_lane
// Purpose : buffers payload words in a small FIFO and drives a continuous
//           lane stream to the transceiver. Gaps are filled with IDLE_WORD
//           and an ALIGN_WORD marker is inserted after every enable and
//           then once per ALIGN_PERIOD output words (0 = only after enable).
// Ports   : tx_clk        - lane clock
//           reset_n       - asynchronous active-low reset
//           tx_enable     - lane enable, low keeps the lane quiet
//           tx_in         - payload stream (slave side of mg_tx_lane_if)
//           mg_tx_data    - word to transceiver
//           mg_tx_valid   - mg_tx_data valid
//           mg_tx_ctrl    - 1 = idle/alignment word, 0 = payload
//           fifo_level    - current FIFO occupancy
//           stat_idle_cnt - idle words emitted (wraps)
module mg_tx_lane #(
  parameter int                DATA_W       = 128,
  parameter int                FIFO_DEPTH   = 8,
  parameter int                ALIGN_PERIOD = 1024,
  parameter logic [DATA_W-1:0] IDLE_WORD    = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0] ALIGN_WORD   = {(DATA_W/8){8'hBC}}
) (
  input  logic                               tx_clk,
  input  logic                               reset_n,
  input  logic                               tx_enable,
  mg_tx_lane_if.slave                        tx_in,
  output logic [DATA_W-1:0]                  mg_tx_data,
  output logic                               mg_tx_valid,
  output logic                               mg_tx_ctrl,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic [31:0]                        stat_idle_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] ALIGN_LAST =
    (ALIGN_PERIOD > 0) ? CNT_W'(ALIGN_PERIOD - 1) : '0;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_OFF, S_ALIGN, S_RUN} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [LVL_W-1:0]  r_level;
  logic [CNT_W-1:0]  r_alignCnt;
  logic [DATA_W-1:0] r_stgData;
  logic              r_stgValid;
  logic              r_stgCtrl;
  logic              r_stgIdle;
  logic [DATA_W-1:0] r_outData;
  logic              r_outValid;
  logic              r_outCtrl;
  logic [31:0]       r_idleCnt;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_alignDue;

  // Ready comes from the registered level only, so a pop while full does
  // not open the input until the following cycle. Held low during reset.
  assign w_ready    = reset_n && (r_level != LVL_FULL);
  assign w_push     = tx_in.tx_valid_in && w_ready;
  assign w_empty    = (r_level == '0);
  assign w_alignDue = (ALIGN_PERIOD != 0) && (r_alignCnt == ALIGN_LAST);
  // A pop happens only on a payload slot: running, enabled, no marker due.
  assign w_pop      = (r_state == S_RUN) && tx_enable && !w_alignDue && !w_empty;

  assign tx_in.tx_ready_out = w_ready;
  assign mg_tx_data    = r_outData;
  assign mg_tx_valid   = r_outValid;
  assign mg_tx_ctrl    = r_outCtrl;
  assign fifo_level    = r_level;
  assign stat_idle_cnt = r_idleCnt;

  // Storage array carries no reset; the level/pointers define what is valid.
  always_ff @(posedge tx_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= tx_in.tx_data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; the level tells
  // full and empty apart.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Word selection: the FSM decides one word per cycle into the stage
  // register, which then feeds the output register. The marker slot takes
  // priority over payload, payload over idle.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_OFF;
      r_alignCnt <= '0;
      r_stgData  <= '0;
      r_stgValid <= 1'b0;
      r_stgCtrl  <= 1'b0;
      r_stgIdle  <= 1'b0;
    end else begin
      r_stgData  <= '0;
      r_stgValid <= 1'b0;
      r_stgCtrl  <= 1'b0;
      r_stgIdle  <= 1'b0;
      case (r_state)
        S_OFF: begin
          if (tx_enable) r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          if (tx_enable) begin
            r_stgData  <= ALIGN_WORD;
            r_stgValid <= 1'b1;
            r_stgCtrl  <= 1'b1;
            r_alignCnt <= '0;
            r_state    <= S_RUN;
          end else begin
            r_state <= S_OFF;
          end
        end
        S_RUN: begin
          if (!tx_enable) begin
            r_state <= S_OFF;
          end else if (w_alignDue) begin
            r_stgData  <= ALIGN_WORD;
            r_stgValid <= 1'b1;
            r_stgCtrl  <= 1'b1;
            r_alignCnt <= '0;
          end else if (!w_empty) begin
            r_stgData  <= r_mem[r_rdPtr];
            r_stgValid <= 1'b1;
            r_alignCnt <= r_alignCnt + 1'b1;
          end else begin
            r_stgData  <= IDLE_WORD;
            r_stgValid <= 1'b1;
            r_stgCtrl  <= 1'b1;
            r_stgIdle  <= 1'b1;
            r_alignCnt <= r_alignCnt + 1'b1;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  // Output register; the idle statistic counts words as they leave.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_outCtrl  <= 1'b0;
      r_idleCnt  <= '0;
    end else begin
      r_outData  <= r_stgData;
      r_outValid <= r_stgValid;
      r_outCtrl  <= r_stgCtrl;
      if (r_stgIdle) r_idleCnt <= r_idleCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mg_tx_lane.sv
// tb_mg_tx_lane
// Purpose : self-checking bench for mg_tx_lane (DATA_W=128, FIFO_DEPTH=4,
//           ALIGN_PERIOD=8) plus a second instance with ALIGN_PERIOD=0.
//           A queue-based lane model predicts every output each cycle.
module tb_mg_tx_lane;
  localparam int DW     = 128;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 8;
  localparam logic [DW-1:0] ALIGN_W = {16{8'hBC}};
  localparam logic [DW-1:0] IDLE_W  = '0;

  localparam int PH_QUIET  = 0;
  localparam int PH_MARK   = 1;
  localparam int PH_STREAM = 2;

  logic tx_clk    = 1'b0;
  logic reset_n   = 1'b0;
  logic tx_enable = 1'b0;
  logic en0       = 1'b1;

  logic [DW-1:0] mg_tx_data;
  logic          mg_tx_valid;
  logic          mg_tx_ctrl;
  logic [2:0]    fifo_level;
  logic [31:0]   stat_idle_cnt;

  logic [DW-1:0] z_data;
  logic          z_valid;
  logic          z_ctrl;
  logic [2:0]    z_level;
  logic [31:0]   z_idle;

  mg_tx_lane_if #(.DATA_W(DW)) bus ();
  mg_tx_lane_if #(.DATA_W(DW)) bus0 ();

  mg_tx_lane #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ALIGN_PERIOD(PERIOD)) dut (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_enable(tx_enable), .tx_in(bus),
    .mg_tx_data(mg_tx_data), .mg_tx_valid(mg_tx_valid), .mg_tx_ctrl(mg_tx_ctrl),
    .fifo_level(fifo_level), .stat_idle_cnt(stat_idle_cnt)
  );

  mg_tx_lane #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ALIGN_PERIOD(0)) dut0 (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_enable(en0), .tx_in(bus0),
    .mg_tx_data(z_data), .mg_tx_valid(z_valid), .mg_tx_ctrl(z_ctrl),
    .fifo_level(z_level), .stat_idle_cnt(z_idle)
  );

  always #5 tx_clk = ~tx_clk;

  int nVec = 0;
  int nMis = 0;
  int zeroAligns = 0;

  // Lane model: buffered words, lane phase, words since last marker, the
  // word chosen for the next slot and the word currently on the outputs.
  logic [DW-1:0] mq[$];
  int            phase;
  int            sinceMark;
  logic [DW-1:0] sData, eData;
  bit            sValid, sCtrl, sIdle, eValid, eCtrl;
  int unsigned   eIdle;

  typedef struct {
    bit            en;
    bit            vin;
    logic [DW-1:0] din;
    logic [DW-1:0] expData;
    bit            expValid;
    bit            expCtrl;
    int            expLevel;
    int            expStat;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    phase = PH_QUIET;
    sinceMark = 0;
    sData = '0; sValid = 0; sCtrl = 0; sIdle = 0;
    eData = '0; eValid = 0; eCtrl = 0;
    eIdle = 0;
  endtask

  // Advances the model across one rising edge given the driven inputs.
  task automatic modelStep(input bit en, input bit vin, input logic [DW-1:0] din);
    bit canTake;
    canTake = (mq.size() < DEPTH);
    eData = sData; eValid = sValid; eCtrl = sCtrl;
    if (sIdle) eIdle++;
    sData = '0; sValid = 0; sCtrl = 0; sIdle = 0;
    case (phase)
      PH_QUIET: if (en) phase = PH_MARK;
      PH_MARK: begin
        if (en) begin
          sData = ALIGN_W; sValid = 1; sCtrl = 1;
          sinceMark = 0;
          phase = PH_STREAM;
        end else begin
          phase = PH_QUIET;
        end
      end
      default: begin
        if (!en) begin
          phase = PH_QUIET;
        end else if (PERIOD != 0 && sinceMark == PERIOD - 1) begin
          sData = ALIGN_W; sValid = 1; sCtrl = 1;
          sinceMark = 0;
        end else if (mq.size() != 0) begin
          sData = mq.pop_front(); sValid = 1; sCtrl = 0;
          sinceMark++;
        end else begin
          sData = IDLE_W; sValid = 1; sCtrl = 1; sIdle = 1;
          sinceMark++;
        end
      end
    endcase
    if (vin && canTake) mq.push_back(din);
  endtask

  task automatic checkModel();
    checkOutput("data", mg_tx_data, eData);
    checkOutput("valid", mg_tx_valid, eValid);
    checkOutput("ctrl", mg_tx_ctrl, eCtrl);
    checkOutput("level", fifo_level, mq.size());
    checkOutput("ready", bus.tx_ready_out, mq.size() < DEPTH);
    checkOutput("idleCnt", stat_idle_cnt, eIdle);
  endtask

  // One clock: drive at the falling edge, step the model, sample at the
  // next falling edge and compare everything against the model.
  task automatic applyStimulus(input bit en, input bit vin,
                               input logic [DW-1:0] din, output bit acc);
    tx_enable = en;
    bus.tx_valid_in = vin;
    bus.tx_data_in = din;
    acc = vin && (mq.size() < DEPTH);
    modelStep(en, vin, din);
    @(posedge tx_clk);
    @(negedge tx_clk);
    if (z_valid && z_ctrl && z_data == ALIGN_W) zeroAligns++;
    checkModel();
  endtask

  initial begin
    bit acc;
    bit en;
    bit pending;
    bit firstSeen;
    bit firstAlign;
    bit markerSeen;
    int wi;
    logic [DW-1:0] word;
    logic [DW-1:0] words[14];
    logic [DW-1:0] got[$];

    tbl[0]  = '{1'b1, 1'b0, DW'(0), DW'(0),  1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, DW'(0), DW'(0),  1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, DW'(0), ALIGN_W, 1'b1, 1'b1, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, DW'(1), IDLE_W,  1'b1, 1'b1, 1, 1};
    tbl[4]  = '{1'b1, 1'b1, DW'(2), IDLE_W,  1'b1, 1'b1, 1, 2};
    tbl[5]  = '{1'b1, 1'b1, DW'(3), DW'(1),  1'b1, 1'b0, 1, 2};
    tbl[6]  = '{1'b1, 1'b0, DW'(0), DW'(2),  1'b1, 1'b0, 0, 2};
    tbl[7]  = '{1'b1, 1'b0, DW'(0), DW'(3),  1'b1, 1'b0, 0, 2};
    tbl[8]  = '{1'b1, 1'b0, DW'(0), IDLE_W,  1'b1, 1'b1, 0, 3};
    tbl[9]  = '{1'b1, 1'b0, DW'(0), IDLE_W,  1'b1, 1'b1, 0, 4};
    tbl[10] = '{1'b1, 1'b0, DW'(0), ALIGN_W, 1'b1, 1'b1, 0, 4};
    tbl[11] = '{1'b1, 1'b0, DW'(0), IDLE_W,  1'b1, 1'b1, 0, 5};

    for (int i = 0; i < 14; i++) words[i] = {32'hC0DE_0000, 64'h0, 32'(i + 1)};

    bus.tx_valid_in = 1'b0;
    bus.tx_data_in = '0;
    bus0.tx_valid_in = 1'b0;
    bus0.tx_data_in = '0;
    modelReset();

    // Reset state
    repeat (2) @(negedge tx_clk);
    checkOutput("rstReady", bus.tx_ready_out, 0);
    checkOutput("rstValid", mg_tx_valid, 0);
    checkOutput("rstLevel", fifo_level, 0);
    reset_n = 1'b1;

    // Start-up markers, idle fill and a three-word burst
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].en, tbl[i].vin, tbl[i].din, acc);
      checkOutput("tblData", mg_tx_data, tbl[i].expData);
      checkOutput("tblValid", mg_tx_valid, tbl[i].expValid);
      checkOutput("tblCtrl", mg_tx_ctrl, tbl[i].expCtrl);
      checkOutput("tblLevel", fifo_level, tbl[i].expLevel);
      checkOutput("tblStat", stat_idle_cnt, tbl[i].expStat);
    end

    // Disabled lane fills up; fifth word waits on the bus
    wi = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1, words[wi], acc);
      if (acc) wi++;
    end
    checkOutput("fullLevel", fifo_level, 4);
    checkOutput("fullReady", bus.tx_ready_out, 0);
    checkOutput("heldCount", wi, 4);

    // Re-enable: marker first, then all five words in order
    got.delete();
    firstSeen = 0;
    firstAlign = 0;
    for (int c = 0; c < 16; c++) begin
      pending = (wi < 5);
      applyStimulus(1'b1, pending, pending ? words[wi] : DW'(0), acc);
      if (acc) wi++;
      if (mg_tx_valid) begin
        if (!firstSeen) begin
          firstSeen = 1;
          firstAlign = mg_tx_ctrl && (mg_tx_data == ALIGN_W);
        end
        if (!mg_tx_ctrl) got.push_back(mg_tx_data);
      end
    end
    checkOutput("reFirstAlign", firstAlign, 1);
    checkOutput("reCount", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) checkOutput("reOrder", got[i], words[i]);

    // Continuous stream across marker slots
    got.delete();
    markerSeen = 0;
    wi = 0;
    for (int c = 0; c < 26; c++) begin
      pending = (wi < 14);
      applyStimulus(1'b1, pending, pending ? words[wi] : DW'(0), acc);
      if (acc) wi++;
      if (mg_tx_valid && !mg_tx_ctrl) got.push_back(mg_tx_data);
      if (mg_tx_valid && mg_tx_ctrl && mg_tx_data == ALIGN_W) markerSeen = 1;
    end
    checkOutput("streamMarker", markerSeen, 1);
    checkOutput("streamCount", got.size(), 14);
    for (int i = 0; i < got.size() && i < 14; i++) checkOutput("streamOrder", got[i], words[i]);

    // Reset mid-burst with three words buffered
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, words[c], acc);
    applyStimulus(1'b1, 1'b0, DW'(0), acc);
    applyStimulus(1'b1, 1'b0, DW'(0), acc);
    applyStimulus(1'b1, 1'b1, words[3], acc);
    bus.tx_valid_in = 1'b0;
    checkOutput("preRstLevel", fifo_level, 3);
    checkOutput("preRstValid", mg_tx_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRstData", mg_tx_data, 0);
    checkOutput("midRstValid", mg_tx_valid, 0);
    checkOutput("midRstCtrl", mg_tx_ctrl, 0);
    checkOutput("midRstLevel", fifo_level, 0);
    checkOutput("midRstReady", bus.tx_ready_out, 0);
    checkOutput("midRstStat", stat_idle_cnt, 0);
    modelReset();
    @(negedge tx_clk);
    reset_n = 1'b1;
    zeroAligns = 0;

    // After release only markers and idles appear on either lane
    for (int c = 0; c < 120; c++) begin
      applyStimulus(1'b1, 1'b0, DW'(0), acc);
      checkOutput("noStale", mg_tx_valid && !mg_tx_ctrl, 0);
    end
    checkOutput("zeroPeriodMarkers", zeroAligns, 1);

    // Randomised traffic with enable toggling
    en = 1;
    pending = 0;
    word = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 4) en = !en;
      if (!pending && $urandom_range(0, 9) < 6) begin
        pending = 1;
        word = {$urandom, $urandom, $urandom, $urandom};
      end
      applyStimulus(en, pending, word, acc);
      if (acc) pending = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/mg_tx_lane.md
Name: mg_tx_lane

Overview:
- Parametrised successor to the single-stage multi-gigabit TX pass-through.
- Accepts words from the order/packet builder over a valid/ready handshake and buffers them in a FIFO.
- Drives a continuous lane stream to the transceiver. Idle words fill gaps and an alignment marker is inserted periodically.
- Sits between the TX packet formatter and the transceiver hard macro, all in the tx_clk domain.

Parameters:
- DATA_W, 128: lane word width in bits.
- FIFO_DEPTH, 8: buffer depth in words; power of two, at least 2.
- ALIGN_PERIOD, 1024: one alignment marker per ALIGN_PERIOD output words; 0 disables periodic markers.
- IDLE_WORD, {DATA_W{1'b0}}: word emitted when the FIFO is empty.
- ALIGN_WORD, {(DATA_W/8){8'hBC}}: alignment marker word.

Ports:
- tx_clk  in  1  lane clock.
- reset_n  in  1  asynchronous active-low reset.
- tx_enable  in  1  lane enable; low means lane quiet.
- tx_data_in  in  DATA_W  payload word.
- tx_valid_in  in  1  payload word valid.
- tx_ready_out  out  1  FIFO can accept a word this cycle.
- mg_tx_data  out  DATA_W  word to transceiver.
- mg_tx_valid  out  1  mg_tx_data valid.
- mg_tx_ctrl  out  1  1 = idle or alignment word; 0 = payload.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- stat_idle_cnt  out  32  idle words emitted; wraps modulo 2^32.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO flushed; fifo_level=0; tx_ready_out=0 while in reset.
  - mg_tx_data=0, mg_tx_valid=0, mg_tx_ctrl=0, stat_idle_cnt=0.
  - Alignment counter=0; state=S_OFF.
  - Reset mid-stream discards all buffered words.
- Input side:
  - A word is pushed on a rising edge when tx_valid_in && tx_ready_out.
  - tx_ready_out = (fifo_level != FIFO_DEPTH), registered-count based, and independent of tx_enable.
  - Pushing while not ready is impossible by construction. The word stays on the bus until accepted.
  - When full, a simultaneous pop does not create same-cycle ready; ready rises the cycle after the pop.
  - With simultaneous push and pop, level is unchanged.
- FSM states: S_OFF, S_ALIGN, S_RUN.
  - S_OFF: mg_tx_valid=0, mg_tx_data=0, mg_tx_ctrl=0. No pops; counters hold. When tx_enable is 1, go to S_ALIGN.
  - S_ALIGN: emit ALIGN_WORD with ctrl=1 and valid=1 for exactly one cycle, clear the alignment counter, go to S_RUN. If tx_enable is 0, go to S_OFF instead.
  - S_RUN: one word per cycle, valid=1, chosen in this priority order:
    - (a) If ALIGN_PERIOD != 0 and the alignment counter equals ALIGN_PERIOD-1: emit ALIGN_WORD with ctrl=1 and clear the counter.
    - (b) Else if the FIFO is non-empty: pop and emit the head with ctrl=0.
    - (c) Else: emit IDLE_WORD with ctrl=1 and increment stat_idle_cnt.
    - The counter increments on every (b) or (c) cycle.
    - If tx_enable is 0, go to S_OFF at the next edge with no word emitted. FIFO contents are retained and a later re-enable passes through S_ALIGN again.
- Outputs are registered. A word pushed at edge k into an empty FIFO in S_RUN appears on mg_tx_data after edge k+2, unless a marker preempts it. A marker delays the word by exactly one cycle.
- Order is preserved; no payload word is dropped or duplicated.
- The FIFO pointers wrap modulo FIFO_DEPTH. fifo_level distinguishes full from empty.

Test Plan (DATA_W=128, FIFO_DEPTH=4, ALIGN_PERIOD=8):
- Reset release with tx_enable=1 and no input: one ALIGN_WORD (ctrl=1), then IDLE_WORD with ctrl=1, then every 8th word after the marker is ALIGN_WORD. stat_idle_cnt increments 7 per 8 cycles.
- Push 0x1, 0x2, 0x3 back-to-back in S_RUN: they appear in order with ctrl=0, first at push-edge+2, with idle before and after.
- tx_enable=0 and push 5 words: tx_ready_out drops after the 4th, fifo_level=4, and the 5th word is held. Re-enable: ALIGN_WORD, then 4 words in order, then the 5th.
- Words arriving continuously across an alignment slot: the marker lands at counter=7 and the payload resumes the next cycle with no loss.
- Assert reset_n low mid-burst with fifo_level=3: outputs go to 0 immediately and fifo_level=0. After release, only ALIGN/IDLE appear; no stale words.
- ALIGN_PERIOD=0 build: only the initial marker appears, and there are no periodic markers over 100 cycles.
